// File: rtl/a1csah_seq_adder_pkg.sv
// Shared definitions for the sequential add-one carry-select adder:
// FSM state encoding and the chunk counter width helper.
package a1csah_seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk configuration still needs a 1-bit counter to stay legal.
  function automatic int count_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/a1csah_chunk.sv
// W-bit hierarchical add-one carry-select adder: each BLK-bit block forms a+b and
// (a+b)+1, the block carry selects one, and block generate/propagate form the group terms.
module a1csah_chunk #(
  parameter int W   = 64,
  parameter int BLK = 8
) (
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         gen,
  output logic         prop,
  output logic         cout
);

  localparam int NB = W / BLK;

  always_comb begin
    logic           carry;
    logic           g_acc;
    logic           p_acc;
    logic           c0;
    logic           pb;
    logic [BLK-1:0] sum0;
    logic [BLK-1:0] sum1;
    s     = '0;
    carry = cin;
    g_acc = 1'b0;
    p_acc = 1'b1;
    c0    = 1'b0;
    pb    = 1'b0;
    sum0  = '0;
    sum1  = '0;
    for (int i = 0; i < NB; i++) begin
      {c0, sum0} = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
      sum1       = sum0 + BLK'(1);
      pb         = &(a[i*BLK +: BLK] ^ b[i*BLK +: BLK]);
      s[i*BLK +: BLK] = carry ? sum1 : sum0;
      // The add-one result carries out only if the block generates or fully propagates.
      g_acc = c0 | (pb & g_acc);
      p_acc = p_acc & pb;
      carry = c0 | (pb & carry);
    end
    gen  = g_acc;
    prop = p_acc;
    cout = carry;
  end

endmodule

// File: rtl/a1csah_seq_adder.sv
// Multi-cycle N-bit adder that walks the operands W bits per cycle through one
// shared a1csah_chunk core, chaining a registered carry and group G/P terms.
module a1csah_seq_adder
  import a1csah_seq_adder_pkg::*;
#(
  parameter int N = 256,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         gen,
  output logic         prop
);

  localparam int CHUNKS = N / W;
  localparam int KW     = count_width(CHUNKS);

  state_t state;
  state_t next_state;

  logic [KW-1:0]              k;
  logic [CHUNKS-1:0][W-1:0]   a_reg;
  logic [CHUNKS-1:0][W-1:0]   b_reg;
  logic [CHUNKS-1:0][W-1:0]   s_reg;
  logic                       carry;
  logic                       g_acc;
  logic                       p_acc;
  logic                       cout_reg;
  logic                       gen_reg;
  logic                       prop_reg;

  logic [W-1:0] core_s;
  logic         core_gen;
  logic         core_prop;
  logic         core_cout;
  logic         last;
  logic         g_next;
  logic         p_next;

  a1csah_chunk #(.W(W)) u_chunk (
    .cin  (carry),
    .a    (a_reg[k]),
    .b    (b_reg[k]),
    .s    (core_s),
    .gen  (core_gen),
    .prop (core_prop),
    .cout (core_cout)
  );

  assign last   = (k == KW'(CHUNKS - 1));
  assign g_next = core_gen | (core_prop & g_acc);
  assign p_next = p_acc & core_prop;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last)      next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign s         = s_reg;
  assign cout      = cout_reg;
  assign gen       = gen_reg;
  assign prop      = prop_reg;

  // Carry into the core is always the registered carry, never the cin port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      s_reg    <= '0;
      carry    <= 1'b0;
      g_acc    <= 1'b0;
      p_acc    <= 1'b1;
      cout_reg <= 1'b0;
      gen_reg  <= 1'b0;
      prop_reg <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            g_acc <= 1'b0;
            p_acc <= 1'b1;
            k     <= '0;
          end
        end
        RUN: begin
          s_reg[k] <= core_s;
          carry    <= core_cout;
          g_acc    <= g_next;
          p_acc    <= p_next;
          k        <= k + 1'b1;
          if (last) begin
            k        <= '0;
            cout_reg <= core_cout;
            gen_reg  <= g_next;
            prop_reg <= p_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_a1csah_seq_adder.sv
// Self-checking bench for a1csah_seq_adder: table vectors, stall/reset corner
// sequences and a random back-to-back run, all checked through a result queue.
module tb_a1csah_seq_adder;

  localparam int N      = 256;
  localparam int W      = 64;
  localparam int CHUNKS = N / W;

  typedef struct {
    logic [N-1:0] s;
    logic         cout;
    logic         gen;
    logic         prop;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    exp_t         e;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         cin;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         gen;
  logic         prop;

  int   total;
  int   bad;
  int   cycle;
  bit   rand_ready;
  exp_t exp_q[$];
  vec_t vecs[6];

  a1csah_seq_adder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .gen       (gen),
    .prop      (prop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t golden(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    exp_t       r;
    logic [N:0] full;
    logic [N:0] gp;
    full   = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    gp     = {1'b0, x} + {1'b0, y};
    r.s    = full[N-1:0];
    r.cout = full[N];
    r.gen  = gp[N];
    r.prop = &(x ^ y);
    return r;
  endfunction

  function automatic logic [N-1:0] rand_n();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Results are popped on the falling edge of any cycle that completes a handshake.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got s=%h expected no result", s);
      end else begin
        e = exp_q.pop_front();
        check_output("sum", s, e.s);
        check_output("cout_gen_prop", {253'd0, cout, gen, prop}, {253'd0, e.cout, e.gen, e.prop});
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check_output("in_ready_timeout", {{(N-1){1'b0}}, in_ready}, 1);
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) check_output(name, {{(N-1){1'b0}}, out_valid}, 1);
  endtask

  task automatic apply_stimulus(input logic [N-1:0] x, input logic [N-1:0] y, input logic c, input exp_t e);
    int lat;
    wait_ready();
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
    a        = rand_n();
    b        = rand_n();
    cin      = ~c;
    wait_valid("out_valid_timeout", lat);
    check_output("latency", lat, CHUNKS);
    tick();
  endtask

  initial begin
    exp_t e;
    int   lat;
    int   prev_acc;
    int   guard;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rc;

    total      = 0;
    bad        = 0;
    cycle      = 0;
    rand_ready = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    cin        = 1'b0;
    a          = '0;
    b          = '0;

    vecs[0] = '{'1, 256'd1, 1'b0, '{256'd0, 1'b1, 1'b1, 1'b0}};
    vecs[1] = '{256'd0, 256'd0, 1'b1, '{256'd1, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{'1, 256'd0, 1'b1, '{256'd0, 1'b1, 1'b0, 1'b1}};
    vecs[3] = '{256'hFFFF_FFFF_FFFF_FFFF, 256'd1, 1'b0, '{256'h1_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{'1, '1, 1'b1, '{'1, 1'b1, 1'b1, 1'b0}};
    vecs[5] = '{256'd5, 256'd7, 1'b0, '{256'd12, 1'b0, 1'b0, 1'b0}};

    tick();
    tick();
    check_output("reset_in_ready", {{(N-1){1'b0}}, in_ready}, 1);
    check_output("reset_out_valid", {{(N-1){1'b0}}, out_valid}, 0);
    check_output("reset_s", s, 0);
    check_output("reset_flags", {253'd0, cout, gen, prop}, 0);
    rst = 1'b0;
    tick();

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].e);

    $display("[TB] consumer stall with in_valid held high");
    out_ready = 1'b0;
    wait_ready();
    a        = 256'd3;
    b        = 256'd4;
    cin      = 1'b0;
    in_valid = 1'b1;
    exp_q.push_back('{256'd7, 1'b0, 1'b0, 1'b0});
    tick();
    a   = 256'd100;
    b   = 256'd23;
    cin = 1'b1;
    wait_valid("stall_out_valid_timeout", lat);
    for (int i = 0; i < 5; i++) begin
      check_output("stall_out_valid", {{(N-1){1'b0}}, out_valid}, 1);
      check_output("stall_in_ready", {{(N-1){1'b0}}, in_ready}, 0);
      check_output("stall_s", s, 256'd7);
      check_output("stall_cout", {{(N-1){1'b0}}, cout}, 0);
      tick();
    end
    out_ready = 1'b1;
    exp_q.push_back('{256'd124, 1'b0, 1'b0, 1'b0});
    tick();
    check_output("release_out_valid", {{(N-1){1'b0}}, out_valid}, 0);
    check_output("release_in_ready", {{(N-1){1'b0}}, in_ready}, 1);
    tick();
    check_output("second_accept", {{(N-1){1'b0}}, in_ready}, 0);
    in_valid = 1'b0;
    wait_valid("second_out_valid_timeout", lat);
    tick();

    $display("[TB] reset during RUN");
    wait_ready();
    a        = 256'd9;
    b        = 256'd9;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_output("midrun_rst_out_valid", {{(N-1){1'b0}}, out_valid}, 0);
    check_output("midrun_rst_in_ready", {{(N-1){1'b0}}, in_ready}, 1);
    check_output("midrun_rst_s", s, 0);
    rst = 1'b0;
    exp_q.delete();
    apply_stimulus(256'd5, 256'd7, 1'b0, '{256'd12, 1'b0, 1'b0, 1'b0});

    $display("[TB] random back-to-back");
    rand_ready = 1'b1;
    prev_acc   = -1;
    for (int op = 0; op < 200; op++) begin
      ra = rand_n();
      rb = rand_n();
      rc = 1'($urandom_range(0, 1));
      if (op % 16 == 3) rb = ~ra;
      if (op % 16 == 7) ra = '1;
      a        = ra;
      b        = rb;
      cin      = rc;
      in_valid = 1'b1;
      wait_ready();
      e = golden(ra, rb, rc);
      exp_q.push_back(e);
      tick();
      if (prev_acc >= 0) check_output("op_spacing_ge6", {{(N-1){1'b0}}, (cycle - prev_acc) >= CHUNKS + 2}, 1);
      prev_acc = cycle;
    end
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    guard      = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    check_output("drain_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
